// File: rtl/axi2ram_capture.sv
// Captures one AIE stream symbol at a time into a simple-dual-port RAM, then drains it to the
// DMA S2MM stream through a credit-limited FWFT output FIFO, NUM_OF_SYMBOL symbols per frame.
module axi2ram_capture #(
    parameter int NUM_OF_SYMBOL   = 14,
    parameter int DEPTH_OF_SYMBOL = 13104,
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 64,
    parameter int OFIFO_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  start_pulse,
    input  logic                  aie2pl_axi_tvld,
    input  logic [DATA_WIDTH-1:0] aie2pl_axi_tdat,
    output logic                  aie2pl_axi_trdy,
    output logic                  dma_axi_tvld,
    output logic [DATA_WIDTH-1:0] dma_axi_tdat,
    output logic                  dma_axi_tlast,
    input  logic                  dma_axi_trdy,
    output logic                  symbol_done,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int PTR_W = $clog2(OFIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_OF_SYMBOL - 1);
    localparam logic [7:0] LAST_SYM = 8'(NUM_OF_SYMBOL - 1);
    localparam logic [PTR_W+1:0] FIFO_SLOTS = (PTR_W + 2)'(OFIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;
    state_t state_reg, state_next;

    logic                  trdy_reg;
    logic                  symbol_done_reg;
    logic [ADDR_WIDTH-1:0] wcnt_reg, rcnt_reg;
    logic [7:0]            sym_cnt_reg;
    logic                  rd_done_reg;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic [DATA_WIDTH-1:0] ram [0:(1 << ADDR_WIDTH) - 1];
    logic [DATA_WIDTH-1:0] rd_data1_reg, rd_data2_reg;
    logic                  rd_vld1_reg, rd_vld2_reg, rd_last1_reg, rd_last2_reg;
    logic [DATA_WIDTH:0]   fifo_mem [OFIFO_DEPTH];
    logic [PTR_W-1:0]      fifo_wptr_reg, fifo_rptr_reg;
    logic [PTR_W:0]        fifo_cnt_reg;

    logic                  start_ok, accept, last_accept, fifo_vld, pop, push, tlast_hs, rd_issue;
    logic [DATA_WIDTH:0]   head;
    logic [PTR_W+1:0]      occupancy;

    assign start_ok    = start_pulse && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign accept      = aie2pl_axi_tvld && trdy_reg;
    assign last_accept = accept && (wcnt_reg == LAST_ADDR);
    assign fifo_vld    = (fifo_cnt_reg != '0);
    assign head        = fifo_mem[fifo_rptr_reg];
    assign pop         = fifo_vld && dma_axi_trdy;
    assign push        = rd_vld2_reg;
    assign tlast_hs    = pop && head[DATA_WIDTH] && (state_reg == ST_DRAIN);
    // Reads still in the RAM pipeline hold a FIFO slot, so the FIFO can never overflow.
    assign occupancy   = (PTR_W + 2)'(fifo_cnt_reg) + (PTR_W + 2)'(rd_vld1_reg)
                       + (PTR_W + 2)'(rd_vld2_reg);
    assign rd_issue    = (state_reg == ST_DRAIN) && !rd_done_reg && (occupancy < FIFO_SLOTS);

    always_ff @(posedge clk) begin
        if (!srstn) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start_ok) state_next = ST_CAPTURE;
            ST_CAPTURE:       if (last_accept) state_next = ST_DRAIN;
            ST_DRAIN:         if (tlast_hs) state_next = (sym_cnt_reg == LAST_SYM) ? ST_DONE : ST_CAPTURE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            trdy_reg        <= 1'b0;
            symbol_done_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            wcnt_reg        <= '0;
            rcnt_reg        <= '0;
            sym_cnt_reg     <= '0;
            rd_done_reg     <= 1'b0;
        end else begin
            trdy_reg        <= (state_reg == ST_CAPTURE) && (state_next == ST_CAPTURE);
            symbol_done_reg <= tlast_hs;
            wr_en_reg       <= accept;
            if (start_ok) begin
                wcnt_reg    <= '0;
                rcnt_reg    <= '0;
                sym_cnt_reg <= '0;
                rd_done_reg <= 1'b0;
            end else if (tlast_hs) begin
                if (sym_cnt_reg != LAST_SYM) sym_cnt_reg <= sym_cnt_reg + 8'd1;
                wcnt_reg    <= '0;
                rcnt_reg    <= '0;
                rd_done_reg <= 1'b0;
            end else begin
                if (accept && !last_accept) wcnt_reg <= wcnt_reg + ADDR_WIDTH'(1);
                if (rd_issue) begin
                    if (rcnt_reg == LAST_ADDR) rd_done_reg <= 1'b1;
                    else                       rcnt_reg    <= rcnt_reg + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Write port lags acceptance by one cycle; DRAIN starts after that write lands.
    always_ff @(posedge clk) begin
        wr_addr_reg <= wcnt_reg;
        wr_data_reg <= aie2pl_axi_tdat;
        if (wr_en_reg) ram[wr_addr_reg] <= wr_data_reg;
        if (rd_issue) rd_data1_reg <= ram[rcnt_reg];
        rd_data2_reg <= rd_data1_reg;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            rd_vld1_reg  <= 1'b0;
            rd_vld2_reg  <= 1'b0;
            rd_last1_reg <= 1'b0;
            rd_last2_reg <= 1'b0;
        end else begin
            rd_vld1_reg  <= rd_issue;
            rd_last1_reg <= rd_issue && (rcnt_reg == LAST_ADDR);
            rd_vld2_reg  <= rd_vld1_reg;
            rd_last2_reg <= rd_last1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wptr_reg] <= {rd_last2_reg, rd_data2_reg};
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            fifo_wptr_reg <= '0;
            fifo_rptr_reg <= '0;
            fifo_cnt_reg  <= '0;
        end else begin
            if (push) fifo_wptr_reg <= fifo_wptr_reg + PTR_W'(1);
            if (pop)  fifo_rptr_reg <= fifo_rptr_reg + PTR_W'(1);
            fifo_cnt_reg <= fifo_cnt_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    assign aie2pl_axi_trdy = trdy_reg;
    assign dma_axi_tvld    = fifo_vld;
    assign dma_axi_tdat    = fifo_vld ? head[DATA_WIDTH-1:0] : '0;
    assign dma_axi_tlast   = fifo_vld && head[DATA_WIDTH];
    assign symbol_done     = symbol_done_reg;
    assign frame_done      = (state_reg == ST_DONE);
    assign busy            = (state_reg == ST_CAPTURE) || (state_reg == ST_DRAIN);
endmodule

// File: tb/tb_axi2ram_capture.sv
// Randomised bench for axi2ram_capture: accepted AIE beats form the expected DMA stream
// (tlast every DEPTH-th beat); a separate monitor checks words, timing and stall stability.
module tb_axi2ram_capture;
    localparam int NUM = 2;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    localparam int DW = 64;
    localparam int OFD = 8;

    logic          clk = 1'b0;
    logic          srstn, start_pulse, aie2pl_axi_tvld, aie2pl_axi_trdy;
    logic [DW-1:0] aie2pl_axi_tdat, dma_axi_tdat;
    logic          dma_axi_tvld, dma_axi_tlast, dma_axi_trdy;
    logic          symbol_done, frame_done, busy;

    axi2ram_capture #(
        .NUM_OF_SYMBOL(NUM), .DEPTH_OF_SYMBOL(DEPTH), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .OFIFO_DEPTH(OFD)
    ) dut (
        .clk(clk), .srstn(srstn), .start_pulse(start_pulse),
        .aie2pl_axi_tvld(aie2pl_axi_tvld), .aie2pl_axi_tdat(aie2pl_axi_tdat),
        .aie2pl_axi_trdy(aie2pl_axi_trdy), .dma_axi_tvld(dma_axi_tvld),
        .dma_axi_tdat(dma_axi_tdat), .dma_axi_tlast(dma_axi_tlast),
        .dma_axi_trdy(dma_axi_trdy), .symbol_done(symbol_done),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0;
    longint      cyc = 0;
    int          dma_duty = 100;
    logic [DW:0] exp_q[$];
    int          beat_idx = 0, sd_count = 0, frame_tlast = 0;
    longint      last_acc_cyc = 0, hs_cyc = -10;
    bit          wait_first = 0, trdy_pend = 0, trdy_prev = 0, stall_prev = 0;
    logic [DW-1:0] prev_d;
    logic        prev_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        dma_axi_trdy = 1'b0;
        forever begin
            @(posedge clk);
            #1 dma_axi_trdy = ($urandom_range(99) < dma_duty);
        end
    end

    // Reference model: every accepted beat becomes the next expected DMA word.
    always @(negedge clk) begin
        if (srstn && aie2pl_axi_tvld && aie2pl_axi_trdy) begin
            exp_q.push_back({(beat_idx % DEPTH) == DEPTH - 1, aie2pl_axi_tdat});
            if ((beat_idx % DEPTH) == DEPTH - 1) begin
                last_acc_cyc = cyc;
                wait_first = 1;
            end
            beat_idx++;
        end
    end

    always @(negedge clk) begin
        logic [DW:0] e;
        if (!srstn) begin
            stall_prev = 0; wait_first = 0; trdy_pend = 0; trdy_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_tvld", DW'(dma_axi_tvld), 1);
                chk("stall_tdat", dma_axi_tdat, prev_d);
                chk("stall_tlast", DW'(dma_axi_tlast), DW'(prev_l));
            end
            if (dma_axi_tvld && wait_first) begin
                chk("first_word_latency", DW'(cyc - last_acc_cyc), 4);
                wait_first = 0;
            end
            if (dma_axi_tvld && dma_axi_trdy) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word: got %0d expected none", dma_axi_tdat);
                end else begin
                    e = exp_q.pop_front();
                    chk("dma_tdat", dma_axi_tdat, e[DW-1:0]);
                    chk("dma_tlast", DW'(dma_axi_tlast), DW'(e[DW]));
                end
                if (dma_axi_tlast) begin
                    hs_cyc = cyc;
                    frame_tlast++;
                    if (frame_tlast < NUM) trdy_pend = 1;
                end
            end
            if (symbol_done) begin
                chk("symbol_done_cycle", DW'(cyc - hs_cyc), 1);
                sd_count++;
            end
            if (aie2pl_axi_trdy && !trdy_prev && trdy_pend) begin
                chk("trdy_rise_cycle", DW'(cyc - hs_cyc), 2);
                trdy_pend = 0;
            end
            stall_prev = dma_axi_tvld && !dma_axi_trdy;
            prev_d = dma_axi_tdat;
            prev_l = dma_axi_tlast;
            trdy_prev = aie2pl_axi_trdy;
        end
    end

    task automatic tick(input bit pulses);
        @(posedge clk);
        #1 start_pulse = pulses && busy && ($urandom_range(99) < 15);
    endtask

    task automatic start();
        start_pulse = 1'b1;
        @(posedge clk);
        #1 start_pulse = 1'b0;
        sd_count = 0; frame_tlast = 0; beat_idx = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_trdy"}, DW'(aie2pl_axi_trdy), 0);
        chk({tag, "_dma_tvld"}, DW'(dma_axi_tvld), 0);
        chk({tag, "_dma_tdat"}, dma_axi_tdat, 0);
        chk({tag, "_dma_tlast"}, DW'(dma_axi_tlast), 0);
        chk({tag, "_symbol_done"}, DW'(symbol_done), 0);
        chk({tag, "_frame_done"}, DW'(frame_done), 0);
        chk({tag, "_busy"}, DW'(busy), 0);
    endtask

    task automatic send_seq(input logic [DW-1:0] base, input int n, input int gap_pct,
                            input bit rnd, input bit pulses);
        bit acc;
        int to;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                aie2pl_axi_tvld = 1'b0;
                repeat ($urandom_range(3, 1)) tick(pulses);
            end
            aie2pl_axi_tvld = 1'b1;
            aie2pl_axi_tdat = rnd ? {$urandom, $urandom} : base + DW'(i);
            acc = 0;
            to = 0;
            while (!acc) begin
                @(negedge clk);
                acc = aie2pl_axi_trdy;
                tick(pulses);
                if (++to > 2000) begin
                    checks++; failures++;
                    $display("FAIL beat_accept_timeout: got no trdy expected trdy (beat %0d)", i);
                    aie2pl_axi_tvld = 1'b0;
                    start_pulse = 1'b0;
                    return;
                end
            end
        end
        aie2pl_axi_tvld = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit pulses);
        int to = 0;
        forever begin
            @(negedge clk);
            if (frame_done) break;
            tick(pulses);
            if (++to > 3000) begin
                checks++; failures++;
                $display("FAIL %s_frame_done_timeout: got 0 expected 1", tag);
                break;
            end
        end
        start_pulse = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_symbol_done_count"}, DW'(sd_count), NUM);
        chk({tag, "_queue_left"}, DW'(exp_q.size()), 0);
        chk({tag, "_frame_done"}, DW'(frame_done), 1);
        chk({tag, "_busy"}, DW'(busy), 0);
        $display("frame %s: symbols=%0d words_left=%0d", tag, sd_count, exp_q.size());
    endtask

    initial begin
        int bad;
        srstn = 1'b0; start_pulse = 1'b0; aie2pl_axi_tvld = 1'b0; aie2pl_axi_tdat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        #1 srstn = 1'b1;
        @(posedge clk); #1;

        // Directed: 0..15 back to back, DMA always ready.
        dma_axi_trdy = 1'b1; dma_duty = 100;
        start();
        send_seq(0, 2 * DEPTH, 0, 0, 0);
        finish_frame("directed", 0);

        // Random gaps on both sides.
        dma_duty = 30;
        start();
        send_seq(0, 2 * DEPTH, 40, 1, 0);
        finish_frame("random", 0);

        // Long DMA stall during DRAIN of symbol 0.
        dma_duty = 0;
        @(posedge clk); #1;
        start();
        send_seq(1000, DEPTH, 0, 0, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (aie2pl_axi_trdy) bad++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_aie_trdy_high_cycles", DW'(bad), 0);
        chk("stall_words_buffered", DW'(dma_axi_tvld), 1);
        dma_duty = 100;
        send_seq(2000, DEPTH, 0, 0, 0);
        finish_frame("stall", 0);

        // Stray start pulses while busy.
        dma_duty = 50;
        start();
        send_seq(0, 2 * DEPTH, 20, 1, 1);
        finish_frame("start_ignored", 1);

        // Reset after 5 beats of symbol 0, then a fresh frame.
        dma_duty = 100;
        start();
        send_seq(200, 5, 0, 0, 0);
        srstn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 srstn = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        @(posedge clk); #1;
        start();
        send_seq(300, 2 * DEPTH, 0, 0, 0);
        finish_frame("after_reset", 0);

        // Restart from DONE with 100..115.
        chk("before_restart_frame_done", DW'(frame_done), 1);
        start();
        @(negedge clk);
        chk("restart_frame_done_low", DW'(frame_done), 0);
        send_seq(100, 2 * DEPTH, 0, 0, 0);
        finish_frame("restart", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
